apb_biu_ws: RTL and testbench

APB3/APB4 slave bus interface unit with wait-state support: it converts APB slave transfers into a registered single-request handshake towards a peripheral register block. The peripheral may stall on `biu_accept`, report errors, and take byte-lane write strobes. A programmable watchdog aborts hung requests. It sits between the system APB fabric and each VxEngine register file, and supersedes the zero-wait-state BIU.

---
 rtl/apb_biu_ws.sv | 120 ++++++++++++
 tb/tb_apb_biu_ws.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_biu_ws.sv
// APB3/APB4 slave bus interface unit with wait states: turns an APB transfer into a
// registered single-request handshake towards a peripheral register block, with a watchdog.
module apb_biu_ws #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 16,
  parameter int ALIGN_CHECK = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   apb_paddr,
  input  logic                    apb_psel,
  input  logic                    apb_penable,
  input  logic                    apb_pwrite,
  input  logic [DATA_WIDTH-1:0]   apb_pwdata,
  input  logic [DATA_WIDTH/8-1:0] apb_pstrb,
  output logic [DATA_WIDTH-1:0]   apb_prdata,
  output logic                    apb_pready,
  output logic                    apb_pslverr,
  output logic [ADDR_WIDTH-1:0]   biu_addr,
  output logic                    biu_enable,
  output logic                    biu_rnw,
  output logic [DATA_WIDTH-1:0]   biu_wdata,
  output logic [DATA_WIDTH/8-1:0] biu_wstrb,
  input  logic [DATA_WIDTH-1:0]   biu_rdata,
  input  logic                    biu_accept,
  input  logic                    biu_error
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST   = (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_WIDTH-1:0]    wd_cnt;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic                    cap_rnw;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [STRB_WIDTH-1:0]   cap_wstrb;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_err;
  logic                    setup;
  logic                    misaligned;
  logic                    timeout_hit;

  assign setup       = apb_psel && !apb_penable;
  assign misaligned  = (ALIGN_CHECK != 0) && ((apb_paddr & ALIGN_MASK) != '0);
  // Accept in the expiry cycle takes priority, so the watchdog only fires without accept.
  assign timeout_hit = (TIMEOUT != 0) && (wd_cnt == CNT_LAST) && !biu_accept;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (setup) state_nxt = misaligned ? ST_RESP : ST_REQ;
      ST_REQ:  if (biu_accept || timeout_hit) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      cap_addr  <= '0;
      cap_rnw   <= 1'b0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (setup) begin
            cap_addr  <= apb_paddr;
            cap_rnw   <= !apb_pwrite;
            cap_wdata <= apb_pwdata;
            cap_wstrb <= apb_pwrite ? apb_pstrb : '0;
            wd_cnt    <= '0;
            resp_err  <= misaligned;
            resp_data <= '0;
          end
        end
        ST_REQ: begin
          if (biu_accept) begin
            resp_data <= cap_rnw ? biu_rdata : '0;
            resp_err  <= biu_error;
          end else if (timeout_hit) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign biu_enable  = (state == ST_REQ);
  assign biu_addr    = cap_addr;
  assign biu_rnw     = cap_rnw;
  assign biu_wdata   = cap_wdata;
  assign biu_wstrb   = cap_wstrb;
  assign apb_pready  = (state == ST_RESP);
  assign apb_pslverr = apb_pready && resp_err;
  assign apb_prdata  = apb_pready ? resp_data : '0;

endmodule

// File: tb/tb_apb_biu_ws.sv
// Self-checking bench for apb_biu_ws: directed scenarios plus randomized transfers
// checked against a cycle-count/result model derived from the transfer rules.
module tb_apb_biu_ws;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] apb_paddr;
  logic          apb_psel;
  logic          apb_penable;
  logic          apb_pwrite;
  logic [DW-1:0] apb_pwdata;
  logic [SW-1:0] apb_pstrb;
  logic [DW-1:0] apb_prdata;
  logic          apb_pready;
  logic          apb_pslverr;
  logic [AW-1:0] biu_addr;
  logic          biu_enable;
  logic          biu_rnw;
  logic [DW-1:0] biu_wdata;
  logic [SW-1:0] biu_wstrb;
  logic [DW-1:0] biu_rdata;
  logic          biu_accept;
  logic          biu_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_biu_ws #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO),
    .ALIGN_CHECK(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .apb_paddr  (apb_paddr),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_pwrite (apb_pwrite),
    .apb_pwdata (apb_pwdata),
    .apb_pstrb  (apb_pstrb),
    .apb_prdata (apb_prdata),
    .apb_pready (apb_pready),
    .apb_pslverr(apb_pslverr),
    .biu_addr   (biu_addr),
    .biu_enable (biu_enable),
    .biu_rnw    (biu_rnw),
    .biu_wdata  (biu_wdata),
    .biu_wstrb  (biu_wstrb),
    .biu_rdata  (biu_rdata),
    .biu_accept (biu_accept),
    .biu_error  (biu_error)
  );

  initial begin
    #2000000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "simulation time limit");
  end

  // Expected outcome of one transfer. delay = cycles after T1 before accept first rises.
  task automatic model(input logic [AW-1:0] addr, input logic wr, input int delay,
                       input logic [DW-1:0] rdata, input logic perr,
                       output int rdy_cyc, output int en_cyc,
                       output logic err, output logic [DW-1:0] data);
    if (addr % SW != 0) begin
      rdy_cyc = 1; en_cyc = 0; err = 1'b1; data = '0;
    end else if (delay < TO) begin
      en_cyc = delay + 1; rdy_cyc = delay + 2; err = perr; data = wr ? '0 : rdata;
    end else begin
      en_cyc = TO; rdy_cyc = TO + 1; err = 1'b1; data = '0;
    end
  endtask

  task automatic run_xfer(input string name, input logic [AW-1:0] addr, input logic wr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          input int delay, input logic [DW-1:0] rdata, input logic perr,
                          input bit tied, input bit drop);
    int            e_rdy, e_en;
    logic          e_err;
    logic [DW-1:0] e_data;
    int            rdy_cyc = 0;
    int            en_cnt  = 0;
    logic          got_err = 1'b0;
    logic [DW-1:0] got_data = '0;
    bit            unstable = 0;
    bit            stray    = 0;
    logic [SW-1:0] e_strb;
    e_strb = wr ? strb : '0;
    model(addr, wr, delay, rdata, perr, e_rdy, e_en, e_err, e_data);
    @(negedge clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = addr; apb_pwrite = wr;
    apb_pwdata = wdata; apb_pstrb = strb;
    biu_accept = tied; biu_rdata = rdata; biu_error = perr;
    for (int k = 1; k <= TO + 8 && rdy_cyc == 0; k++) begin
      @(negedge clk);
      if (drop) begin apb_psel = 1'b0; apb_penable = 1'b0; end
      else apb_penable = 1'b1;
      if (biu_enable === 1'b1) begin
        en_cnt++;
        if (biu_addr !== addr || biu_rnw !== !wr || biu_wstrb !== e_strb ||
            (wr && biu_wdata !== wdata))
          unstable = 1;
      end
      if (apb_pready === 1'b1) begin
        rdy_cyc = k; got_err = apb_pslverr; got_data = apb_prdata;
        apb_psel = 1'b0; apb_penable = 1'b0;
      end else if (apb_pready !== 1'b0 || apb_pslverr !== 1'b0 || apb_prdata !== '0) begin
        stray = 1;
      end
      biu_accept = tied || (k == delay + 1);
    end
    biu_accept = 1'b0;
    checks++;
    if (rdy_cyc !== e_rdy) begin
      errors++;
      $display("FAIL %s pready_cycle got %0d want %0d (0 = never within budget)", name, rdy_cyc, e_rdy);
    end
    checks++;
    if (en_cnt !== e_en) begin
      errors++; $display("FAIL %s enable_cycles got %0d want %0d", name, en_cnt, e_en);
    end
    checks++;
    if (got_err !== e_err) begin
      errors++; $display("FAIL %s pslverr got %b want %b", name, got_err, e_err);
    end
    checks++;
    if (got_data !== e_data) begin
      errors++; $display("FAIL %s prdata got %h want %h", name, got_data, e_data);
    end
    checks++;
    if (unstable !== 1'b0) begin
      errors++; $display("FAIL %s biu_request_fields got unstable want addr=%h rnw=%b strb=%b", name, addr, !wr, e_strb);
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++; $display("FAIL %s response_outside_resp got nonzero want zero", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (apb_pready  !== 1'b0) begin errors++; $display("FAIL reset_pready got %b want 0", apb_pready); end
    checks++; if (apb_pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b want 0", apb_pslverr); end
    checks++; if (apb_prdata  !== '0)   begin errors++; $display("FAIL reset_prdata got %h want 0", apb_prdata); end
    checks++; if (biu_enable  !== 1'b0) begin errors++; $display("FAIL reset_enable got %b want 0", biu_enable); end
    checks++; if (biu_addr    !== '0)   begin errors++; $display("FAIL reset_addr got %h want 0", biu_addr); end
    checks++; if (biu_rnw     !== 1'b0) begin errors++; $display("FAIL reset_rnw got %b want 0", biu_rnw); end
    checks++; if (biu_wdata   !== '0)   begin errors++; $display("FAIL reset_wdata got %h want 0", biu_wdata); end
    checks++; if (biu_wstrb   !== '0)   begin errors++; $display("FAIL reset_wstrb got %b want 0", biu_wstrb); end
    rst = 1'b0;
  endtask

  task automatic test_read_tied;
    run_xfer("read_tied", 32'h0000_000C, 1'b0, 32'h1234_5678, 4'hF, 0, 32'hFEFE_FAFA, 1'b0, 1, 0);
  endtask

  task automatic test_write_delayed;
    run_xfer("write_delay4", 32'h0000_000C, 1'b1, 32'hF1F2_F3F4, 4'b0101, 4, 32'hDEAD_BEEF, 1'b0, 0, 0);
  endtask

  task automatic test_misaligned;
    run_xfer("misaligned_read", 32'h0000_0006, 1'b0, 32'h0, 4'h0, 0, 32'hAAAA_5555, 1'b0, 0, 0);
  endtask

  task automatic test_timeout;
    run_xfer("timeout_expire", 32'h0000_0100, 1'b0, 32'h0, 4'h0, 1000, 32'h1111_2222, 1'b0, 0, 0);
    run_xfer("accept_at_expiry", 32'h0000_0104, 1'b0, 32'h0, 4'h0, TO - 1, 32'h3333_4444, 1'b0, 0, 0);
  endtask

  task automatic test_error_back_to_back;
    run_xfer("write_error", 32'h0000_0020, 1'b1, 32'hCAFE_F00D, 4'b1111, 1, 32'h0, 1'b1, 0, 0);
    run_xfer("b2b_read", 32'h0000_0024, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 1'b0, 0, 0);
    run_xfer("zero_strobe_write", 32'h0000_0028, 1'b1, 32'h5A5A_5A5A, 4'b0000, 2, 32'h0, 1'b0, 0, 0);
  endtask

  task automatic test_psel_drop;
    run_xfer("psel_drop", 32'h0000_0030, 1'b0, 32'h0, 4'h0, 2, 32'h7777_8888, 1'b0, 0, 1);
    run_xfer("after_drop", 32'h0000_0034, 1'b0, 32'h0, 4'h0, 0, 32'h9999_0000, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 32'h0000_0040; apb_pwrite = 1'b0;
    biu_accept = 1'b0;
    repeat (3) begin
      @(negedge clk);
      apb_penable = 1'b1;
    end
    checks++;
    if (biu_enable !== 1'b1) begin errors++; $display("FAIL midreset_enable_before got %b want 1", biu_enable); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (biu_enable !== 1'b0) begin errors++; $display("FAIL midreset_enable_after got %b want 0", biu_enable); end
    checks++;
    if (apb_pready !== 1'b0) begin errors++; $display("FAIL midreset_pready got %b want 0", apb_pready); end
    rst = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0;
    @(negedge clk);
    checks++;
    if (apb_pready !== 1'b0) begin errors++; $display("FAIL midreset_no_late_pready got %b want 0", apb_pready); end
    run_xfer("after_midreset", 32'h0000_0044, 1'b0, 32'h0, 4'h0, 1, 32'h4242_4242, 1'b0, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic          w;
      int            d;
      a = $urandom;
      if ($urandom_range(3) != 0) a = a & ~32'h3;
      w = 1'($urandom_range(1));
      d = int'($urandom_range(TO + 3));
      run_xfer("random", a, w, $urandom, 4'($urandom), d, $urandom,
               1'($urandom_range(1)), 0, 0);
    end
  endtask

  initial begin
    apb_paddr = '0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    apb_pwdata = '0; apb_pstrb = '0; biu_rdata = '0; biu_accept = 1'b0; biu_error = 1'b0;
    test_reset;
    test_read_tied;
    test_write_delayed;
    test_misaligned;
    test_timeout;
    test_error_back_to_back;
    test_psel_drop;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
